// File: rtl/demorgan_pipe.sv
// demorgan_pipe: two-stage valid/ready pipeline that evaluates both sides of a
// selectable De Morgan identity over WIDTH-bit operands, flags any disagreement
// between the two sides, and keeps saturating transaction and mismatch counts.
// fault_mask is XOR'd into the left-hand side so the error path can be exercised.
module demorgan_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] fault_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y_lhs,
  output logic [WIDTH-1:0] y_rhs,
  output logic             mismatch,
  output logic [CNT_W-1:0] txn_count,
  output logic [CNT_W-1:0] err_count,
  input  logic             clear
);

  // Identity selected by the mode field of a beat.
  typedef enum logic [1:0] {
    MODE_NOR  = 2'd0,  // ~A & ~B   vs  ~(A | B)
    MODE_NAND = 2'd1,  // ~A | ~B   vs  ~(A & B)
    MODE_AND  = 2'd2,  //  A &  B   vs  ~(~A | ~B)
    MODE_OR   = 2'd3   //  A |  B   vs  ~(~A & ~B)
  } mode_e;

  // Stage 1 state
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_b_q, s1_na_q, s1_nb_q;
  mode_e            s1_mode_q;

  // Stage 2 state (drives the outputs directly)
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] y_lhs_q, y_lhs_d;
  logic [WIDTH-1:0] y_rhs_q, y_rhs_d;
  logic             mismatch_q, mismatch_d;

  // Counters
  logic [CNT_W-1:0] txn_q, txn_d;
  logic [CNT_W-1:0] err_q, err_d;

  logic             s2_adv;
  logic             in_fire;
  logic             out_fire;
  logic [WIDTH-1:0] lhs_raw, rhs_raw;

  // Stage 2 can take a new beat when it is empty or its beat is leaving now;
  // stage 1 can take one when it is empty or can hand its beat on.
  assign s2_adv   = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  // Stage 1 occupancy: refreshed whenever stage 1 is able to accept.
  always_comb begin
    s1_valid_d = in_ready ? in_valid : s1_valid_q;
  end

  // Stage 1 valid register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block evaluation order.
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
    end
  end

  // Stage 1 operand capture on an accepted beat.
  // NOTE: payload registers carry no reset; they are only observed while their
  // valid bit is set, and the valid bits are reset.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_a_q    <= a;
      s1_b_q    <= b;
      s1_na_q   <= ~a;
      s1_nb_q   <= ~b;
      s1_mode_q <= mode_e'(mode);
    end
  end

  // Evaluate both sides of the selected identity from the stage 1 registers.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    lhs_raw = '0;
    rhs_raw = '0;
    unique case (s1_mode_q)
      MODE_NOR: begin
        lhs_raw = s1_na_q & s1_nb_q;
        rhs_raw = ~(s1_a_q | s1_b_q);
      end
      MODE_NAND: begin
        lhs_raw = s1_na_q | s1_nb_q;
        rhs_raw = ~(s1_a_q & s1_b_q);
      end
      MODE_AND: begin
        lhs_raw = s1_a_q & s1_b_q;
        rhs_raw = ~(s1_na_q | s1_nb_q);
      end
      MODE_OR: begin
        lhs_raw = s1_a_q | s1_b_q;
        rhs_raw = ~(s1_na_q & s1_nb_q);
      end
      default: begin
        lhs_raw = '0;
        rhs_raw = '0;
      end
    endcase
  end

  // Stage 2 next state: load on advance, otherwise hold so stalled results stay put.
  always_comb begin
    out_valid_d = s2_adv ? s1_valid_q : out_valid_q;
    y_lhs_d     = y_lhs_q;
    y_rhs_d     = y_rhs_q;
    mismatch_d  = mismatch_q;
    if (s2_adv && s1_valid_q) begin
      y_lhs_d    = lhs_raw ^ fault_mask;
      y_rhs_d    = rhs_raw;
      mismatch_d = |((lhs_raw ^ fault_mask) ^ rhs_raw);
    end
  end

  // Stage 2 result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      y_lhs_q     <= '0;
      y_rhs_q     <= '0;
      mismatch_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      y_lhs_q     <= y_lhs_d;
      y_rhs_q     <= y_rhs_d;
      mismatch_q  <= mismatch_d;
    end
  end

  // Counter next state: clear has priority, increments stop at all-ones.
  always_comb begin
    txn_d = txn_q;
    err_d = err_q;
    if (clear) begin
      txn_d = '0;
      err_d = '0;
    end else if (out_fire) begin
      if (txn_q != '1)
        txn_d = txn_q + CNT_W'(1);
      if (mismatch_q && (err_q != '1))
        err_d = err_q + CNT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_q <= '0;
      err_q <= '0;
    end else begin
      txn_q <= txn_d;
      err_q <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y_lhs     = y_lhs_q;
  assign y_rhs     = y_rhs_q;
  assign mismatch  = mismatch_q;
  assign txn_count = txn_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_demorgan_pipe.sv
// Self-checking bench for demorgan_pipe. A negedge monitor compares every
// output beat against a queue-based reference model, checks counters, in_ready
// and stall stability. A second instance with 2-bit counters shares all inputs
// so counter saturation is observed on the same traffic.
module tb_demorgan_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a, b, fault_mask;
  logic [1:0]   mode;
  logic         out_ready;
  logic         clear;

  logic         in_ready, out_valid, mismatch;
  logic [W-1:0] y_lhs, y_rhs;
  logic [15:0]  txn_count, err_count;

  logic         in_ready_s, out_valid_s, mismatch_s;
  logic [W-1:0] y_lhs_s, y_rhs_s;
  logic [1:0]   txn_count_s, err_count_s;

  demorgan_pipe #(.WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .fault_mask(fault_mask),
    .out_valid(out_valid), .out_ready(out_ready),
    .y_lhs(y_lhs), .y_rhs(y_rhs), .mismatch(mismatch),
    .txn_count(txn_count), .err_count(err_count), .clear(clear)
  );

  demorgan_pipe #(.WIDTH(W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .a(a), .b(b), .mode(mode), .fault_mask(fault_mask),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .y_lhs(y_lhs_s), .y_rhs(y_rhs_s), .mismatch(mismatch_s),
    .txn_count(txn_count_s), .err_count(err_count_s), .clear(clear)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: the identity table evaluated directly on the operands.
  function automatic logic [2*W-1:0] ref_sides(input logic [1:0] m, input logic [W-1:0] x,
                                               input logic [W-1:0] y);
    logic [W-1:0] l, r;
    case (m)
      2'd0:    begin l = ~x & ~y; r = ~(x | y);   end
      2'd1:    begin l = ~x | ~y; r = ~(x & y);   end
      2'd2:    begin l = x & y;   r = ~(~x | ~y); end
      default: begin l = x | y;   r = ~(~x & ~y); end
    endcase
    return {l, r};
  endfunction

  typedef struct {
    logic [W-1:0] a, b, fm;
    logic [1:0]   mode;
    int           acc_cyc;
  } beat_t;

  beat_t        q[$];
  beat_t        e;
  int           cyc = 0;
  int           m_txn = 0, m_err = 0, m_txn_s = 0, m_err_s = 0;
  bit           hs_in = 0;
  bit           lat_chk = 0;
  int           run = 0, max_run = 0;
  bit           prev_stall = 0;
  logic [W-1:0] st_lhs, st_rhs;
  logic         st_mis;

  // Monitor: samples mid-cycle, so every value seen is what the next rising
  // edge will act on.
  always @(negedge clk) begin
    logic [2*W-1:0] sides;
    logic [W-1:0]   el, er;
    logic           em;
    bit             ofire;
    cyc++;
    if (!rst_n) begin
      q.delete();
      m_txn = 0; m_err = 0; m_txn_s = 0; m_err_s = 0;
      hs_in = 0; prev_stall = 0; run = 0;
    end else begin
      check("txn_count", 32'(txn_count), 32'(m_txn));
      check("err_count", 32'(err_count), 32'(m_err));
      check("txn_count_sat", 32'(txn_count_s), 32'(m_txn_s));
      check("err_count_sat", 32'(err_count_s), 32'(m_err_s));
      check("in_ready", 32'(in_ready), 32'(!(q.size() == 2 && !out_ready)));
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_lhs", 32'(y_lhs), 32'(st_lhs));
        check("stall_rhs", 32'(y_rhs), 32'(st_rhs));
        check("stall_mis", 32'(mismatch), 32'(st_mis));
      end
      em = 1'b0;
      ofire = out_valid && out_ready;
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_out_valid", 32'(out_valid), 32'd0);
          ofire = 1'b0;
        end else begin
          e = q[0];
          sides = ref_sides(e.mode, e.a, e.b);
          el = sides[2*W-1:W] ^ e.fm;
          er = sides[W-1:0];
          em = (el != er);
          check("y_lhs", 32'(y_lhs), 32'(el));
          check("y_rhs", 32'(y_rhs), 32'(er));
          check("mismatch", 32'(mismatch), 32'(em));
          if (e.mode == 2'd0 && e.a == 8'hA5 && e.b == 8'h3C && e.fm == 8'h00) begin
            check("nor_a5_3c_lhs", 32'(y_lhs), 32'h42);
            check("nor_a5_3c_rhs", 32'(y_rhs), 32'h42);
          end
          if (e.mode == 2'd1 && e.a == 8'hF0 && e.b == 8'h0F && e.fm == 8'h01) begin
            check("fault_lhs", 32'(y_lhs), 32'hFE);
            check("fault_rhs", 32'(y_rhs), 32'hFF);
            check("fault_mis", 32'(mismatch), 32'd1);
          end
          if (ofire) begin
            void'(q.pop_front());
            if (lat_chk) check("latency", 32'(cyc - e.acc_cyc), 32'd2);
          end
        end
      end
      if (clear) begin
        m_txn = 0; m_err = 0; m_txn_s = 0; m_err_s = 0;
      end else if (ofire) begin
        if (m_txn < 65535) m_txn++;
        if (m_txn_s < 3) m_txn_s++;
        if (em && m_err < 65535) m_err++;
        if (em && m_err_s < 3) m_err_s++;
      end
      hs_in = in_valid && in_ready;
      if (hs_in) q.push_back('{a: a, b: b, fm: fault_mask, mode: mode, acc_cyc: cyc});
      if (q.size() > 2) check("capacity", 32'(q.size()), 32'd2);
      run = out_valid ? run + 1 : 0;
      if (run > max_run) max_run = run;
      prev_stall = out_valid && !out_ready;
      st_lhs = y_lhs; st_rhs = y_rhs; st_mis = mismatch;
    end
  end

  logic [W-1:0] ba[64], bb[64];
  logic [1:0]   bm[64];
  int           pat[4] = '{1, 0, 0, 1};

  // Present beats ba/bb/bm[0..n-1] until all accepted, then drain.
  // iv_pol: 0 = in_valid always, 1 = random gaps.
  // or_pol: 0 = out_ready=1, 1 = pattern 1,0,0,1, 2 = random.
  task automatic send_beats(input int n, input int iv_pol, input int or_pol);
    int idx = 0;
    int k = 0;
    int g;
    while (1) begin
      @(posedge clk); #1;
      if (hs_in) idx++;
      if (idx >= n || k > 4000) break;
      in_valid = (iv_pol == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      a = ba[idx]; b = bb[idx]; mode = bm[idx];
      case (or_pol)
        0:       out_ready = 1'b1;
        1:       out_ready = pat[k % 4] != 0;
        default: out_ready = $urandom_range(0, 1) != 0;
      endcase
      k++;
    end
    if (idx < n) check("send_timeout", 32'(idx), 32'(n));
    in_valid = 1'b0;
    out_ready = 1'b1;
    g = 0;
    while (q.size() != 0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (q.size() != 0) check("drain_timeout", 32'(q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    clear = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_y_lhs"}, 32'(y_lhs), 32'd0);
    check({tag, "_y_rhs"}, 32'(y_rhs), 32'd0);
    check({tag, "_mismatch"}, 32'(mismatch), 32'd0);
    check({tag, "_txn"}, 32'(txn_count), 32'd0);
    check({tag, "_err"}, 32'(err_count), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_txn_sat"}, 32'(txn_count_s), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] vals[4];
    int n;
    vals = '{8'h00, 8'hFF, 8'hA5, 8'h3C};
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clear = 1'b0;
    a = '0; b = '0; mode = '0; fault_mask = '0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("por");
    rst_n = 1'b1;

    // Exhaustive identities over the corner operand set.
    n = 0;
    for (int m = 0; m < 4; m++)
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          bm[n] = 2'(m); ba[n] = vals[i]; bb[n] = vals[j]; n++;
        end
    send_beats(64, 0, 0);
    check("exh_txn", 32'(txn_count), 32'd64);
    check("exh_err", 32'(err_count), 32'd0);

    // Fault injection on a single NAND beat.
    n = m_err;
    fault_mask = 8'h01;
    ba[0] = 8'hF0; bb[0] = 8'h0F; bm[0] = 2'd1;
    send_beats(1, 0, 0);
    check("fault_err_inc", 32'(err_count), 32'(n + 1));
    fault_mask = 8'h00;

    // Backpressure: 10 distinct operands, out_ready 1,0,0,1 repeating.
    for (int i = 0; i < 10; i++) begin
      ba[i] = 8'(i * 17 + 3); bb[i] = 8'($urandom); bm[i] = 2'($urandom);
    end
    send_beats(10, 0, 1);

    // Throughput and latency: 8 back-to-back beats, out_ready held high.
    for (int i = 0; i < 8; i++) begin
      ba[i] = 8'($urandom); bb[i] = 8'($urandom); bm[i] = 2'(i);
    end
    lat_chk = 1; max_run = 0;
    send_beats(8, 0, 0);
    lat_chk = 0;
    check("throughput_run", 32'(max_run), 32'd8);

    // Random traffic, fault mask fixed while each batch is in flight.
    for (int p = 0; p < 6; p++) begin
      fault_mask = (p % 2 == 0) ? 8'h00 : 8'($urandom);
      for (int i = 0; i < 40; i++) begin
        ba[i] = 8'($urandom); bb[i] = 8'($urandom); bm[i] = 2'($urandom);
      end
      send_beats(40, 1, 2);
    end
    fault_mask = 8'h00;

    // Saturation with 2-bit counters, then clear coincident with a handshake.
    do_reset();
    fault_mask = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      ba[i] = 8'($urandom); bb[i] = 8'($urandom); bm[i] = 2'($urandom);
    end
    send_beats(6, 0, 0);
    check("sat_err", 32'(err_count_s), 32'd3);
    check("sat_txn", 32'(txn_count_s), 32'd3);
    check("wide_err", 32'(err_count), 32'd6);
    out_ready = 1'b0; in_valid = 1'b1; a = 8'h5A; b = 8'hC3; mode = 2'd2;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 check("held_out_valid", 32'(out_valid), 32'd1);
    clear = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    check("clear_txn_sat", 32'(txn_count_s), 32'd0);
    check("clear_err_sat", 32'(err_count_s), 32'd0);
    check("clear_txn", 32'(txn_count), 32'd0);
    check("clear_out_valid", 32'(out_valid), 32'd0);
    fault_mask = 8'h00;
    @(posedge clk); #1;

    // Reset mid-stream with both stages holding a beat.
    out_ready = 1'b0; in_valid = 1'b1; a = 8'h11; b = 8'h22; mode = 2'd3;
    for (int i = 0; i < 10 && q.size() < 2; i++) begin
      @(posedge clk); #1;
      if (hs_in) a = a + 8'd1;
    end
    check("inflight_two", 32'(q.size()), 32'd2);
    check("full_in_ready", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0; out_ready = 1'b1; rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_idle", 32'(out_valid), 32'd0);
    end
    ba[0] = 8'h0F; bb[0] = 8'hF0; bm[0] = 2'd0;
    send_beats(1, 0, 0);
    check("post_rst_txn", 32'(txn_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/demorgan_pipe.md
# demorgan_pipe

Parametrised, pipelined successor to the single-bit De Morgan gate block. It accepts pairs of WIDTH-bit operands over a valid/ready handshake and computes both sides of a selected De Morgan identity bitwise. It compares the two sides, flags mismatches, and keeps saturating transaction and mismatch counters. It sits between a stimulus source and a checker/scoreboard as a self-checking logic datapath; a fault-mask input lets benches exercise the error path.

## Interface
- WIDTH, 8, operand/result width in bits (>=1)
- CNT_W, 16, width of each counter (>=2)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept operand beat
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- mode  in  2  identity select, captured with the beat
- fault_mask  in  WIDTH  XOR'd into lhs at stage 2, sampled when stage 2 loads
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts result
- y_lhs  out  WIDTH  left-hand side result
- y_rhs  out  WIDTH  right-hand side result
- mismatch  out  1  y_lhs != y_rhs for the current beat
- txn_count  out  CNT_W  completed output handshakes, saturating
- err_count  out  CNT_W  completed handshakes with mismatch=1, saturating
- clear  in  1  synchronous zero of both counters

## Operation
- Modes, bitwise over WIDTH:
  - 0: lhs = ~A & ~B, rhs = ~(A | B)
  - 1: lhs = ~A | ~B, rhs = ~(A & B)
  - 2: lhs = A & B, rhs = ~(~A | ~B)
  - 3: lhs = A | B, rhs = ~(~A & ~B)
- Stage 1 (S1) registers A, B, ~A, ~B, mode and s1_valid. Load occurs when in_valid & in_ready.
- Stage 2 (S2) computes lhs ^ fault_mask and rhs from S1 registers. It registers y_lhs, y_rhs, mismatch (= |(y_lhs ^ y_rhs)) and out_valid.
- Advance rules:
  - s2_adv = !out_valid | out_ready
  - in_ready = !s1_valid | s2_adv, combinational
  - S1 contents move to S2 when s2_adv.
  - out_valid next = s1_valid when s2_adv, else holds.
  - s1_valid next = in_valid & in_ready when in_ready, else holds.
- Stalled outputs hold y_lhs, y_rhs and mismatch stable until the handshake completes.
- Counters update on each output handshake (out_valid & out_ready):
  - txn_count += 1
  - err_count += 1 if mismatch
  - Both saturate at 2^CNT_W-1 with no wrap.
- clear=1 forces both counters to 0 next edge; clear wins over a simultaneous increment. Pipeline is unaffected by clear.
- Reset (rst_n=0, any time, including mid-stall): s1_valid=0, out_valid=0, y_lhs=0, y_rhs=0, mismatch=0, txn_count=0, err_count=0. in_ready reads 1 during and after reset. In-flight beats are discarded with no output.

## Timing
- Latency: beat accepted at edge N gives out_valid=1 after edge N+1 (2 clk), provided out_ready is held high.
- Throughput: 1 beat/clk with out_ready=1 continuous; no bubbles inserted.
- Capacity: 2 beats. With out_ready=0, in_ready falls after S1 and S2 are both full, i.e. after at most 2 accepted beats.
- in_ready depends combinationally on out_ready; no other input-to-output combinational path.
- Counters reflect a handshake on the edge after it.
- Beat order is preserved; no beat is dropped or duplicated under any in_valid/out_ready pattern.

## Test plan
- Reset: assert rst_n=0 mid-stream with 2 beats in flight -> all outputs 0, in_ready=1, no out_valid after release until a new beat arrives.
- Exhaustive identities: WIDTH=8, fault_mask=0, all 4 modes, a,b in {0x00,0xFF,0xA5,0x3C}, out_ready=1 -> mismatch=0 every beat. Mode 0, a=0xA5, b=0x3C gives y_lhs=y_rhs=0x42. txn_count=64, err_count=0.
- Fault injection: mode 1, a=0xF0, b=0x0F, fault_mask=0x01 -> y_lhs=0xFE, y_rhs=0xFF, mismatch=1, err_count increments by 1.
- Backpressure: stream 10 beats of distinct a, out_ready toggling with pattern 1,0,0,1… -> outputs in order, none lost, stalled values stable; in_ready=0 only when both stages are full.
- Saturation: CNT_W=2, 6 mismatching beats -> err_count=3 and txn_count=3 held. Then clear coincident with a handshake -> both counters read 0.
- Throughput: 8 back-to-back beats with out_ready=1 -> out_valid high for 8 consecutive cycles starting 2 cycles after the first accept.
